// File: rtl/veda_mem_ctrl.sv
// Data-memory initiator: one load/store at a time over valid/ready,
// fixed read latency, out-of-range addresses answered with an error.
module veda_mem_ctrl #(
    parameter int DEPTH  = 100,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_w_en,
    output logic              mem_mode,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD_WAIT,
        RESP
    } state_t;

    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [3:0]        CNT_INIT = 4'(RD_LAT - 1);

    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic              w_en_n, mode_n, valid_n, err_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] din_n, rdata_n;

    assign busy      = (state != IDLE);
    assign req_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            mem_w_en    <= 1'b0;
            mem_mode    <= 1'b1;
            mem_address <= '0;
            mem_datain  <= '0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            mem_w_en    <= w_en_n;
            mem_mode    <= mode_n;
            mem_address <= addr_n;
            mem_datain  <= din_n;
            resp_valid  <= valid_n;
            resp_rdata  <= rdata_n;
            resp_err    <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        w_en_n  = mem_w_en;
        mode_n  = mem_mode;
        addr_n  = mem_address;
        din_n   = mem_datain;
        valid_n = resp_valid;
        rdata_n = resp_rdata;
        err_n   = resp_err;

        unique case (state)
            IDLE: begin
                w_en_n = 1'b0;
                mode_n = 1'b1;
                if (req_valid && req_ready) begin
                    if (req_addr >= DEPTH_A) begin
                        // memory pins stay untouched on a rejected address
                        state_n = RESP;
                        valid_n = 1'b1;
                        err_n   = 1'b1;
                        rdata_n = '0;
                    end else if (req_we) begin
                        state_n = WR;
                        mode_n  = 1'b0;
                        w_en_n  = 1'b1;
                        addr_n  = req_addr;
                        din_n   = req_wdata;
                    end else begin
                        state_n = RD_WAIT;
                        mode_n  = 1'b1;
                        w_en_n  = 1'b0;
                        addr_n  = req_addr;
                        cnt_n   = CNT_INIT;
                    end
                end
            end
            WR: begin
                state_n = RESP;
                valid_n = 1'b1;
                rdata_n = mem_datain;
                err_n   = 1'b0;
                w_en_n  = 1'b0;
                mode_n  = 1'b1;
                din_n   = '0;
            end
            RD_WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    state_n = RESP;
                    valid_n = 1'b1;
                    rdata_n = mem_dataout;
                    err_n   = 1'b0;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_veda_mem_ctrl.sv
// Bench for veda_mem_ctrl: two instances (read latency 1 and 3) share
// the request stream and are checked against an abstract memory model.
module tb_veda_mem_ctrl;

    localparam int DEPTH = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, resp_ready;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;

    logic        a_req_ready, a_resp_valid, a_resp_err;
    logic        a_mem_w_en, a_mem_mode, a_busy;
    logic [8:0]  a_mem_address;
    logic [31:0] a_resp_rdata, a_mem_datain, a_mem_dataout;

    logic        b_req_ready, b_resp_valid, b_resp_err;
    logic        b_mem_w_en, b_mem_mode, b_busy;
    logic [8:0]  b_mem_address;
    logic [31:0] b_resp_rdata, b_mem_datain, b_mem_dataout;

    logic [31:0] a_mem   [0:511];
    logic [31:0] b_mem   [0:511];
    logic [31:0] ref_mem [0:511];

    int a_wen = 0;
    int b_wen = 0;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    veda_mem_ctrl #(.RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(a_req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(a_resp_valid), .resp_ready(resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
        .mem_w_en(a_mem_w_en), .mem_mode(a_mem_mode),
        .mem_address(a_mem_address), .mem_datain(a_mem_datain),
        .mem_dataout(a_mem_dataout), .busy(a_busy)
    );

    veda_mem_ctrl #(.RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(b_req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .mem_w_en(b_mem_w_en), .mem_mode(b_mem_mode),
        .mem_address(b_mem_address), .mem_datain(b_mem_datain),
        .mem_dataout(b_mem_dataout), .busy(b_busy)
    );

    // simple data memories: asynchronous read, write on rising edge
    assign a_mem_dataout = (int'(a_mem_address) < DEPTH) ? a_mem[a_mem_address] : 32'h0;
    assign b_mem_dataout = (int'(b_mem_address) < DEPTH) ? b_mem[b_mem_address] : 32'h0;

    always @(posedge clk) begin
        if (a_mem_w_en && !a_mem_mode && int'(a_mem_address) < DEPTH)
            a_mem[a_mem_address] <= a_mem_datain;
        if (b_mem_w_en && !b_mem_mode && int'(b_mem_address) < DEPTH)
            b_mem[b_mem_address] <= b_mem_datain;
        if (a_mem_w_en) a_wen <= a_wen + 1;
        if (b_mem_w_en) b_wen <= b_wen + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic txn(input logic we, input logic [8:0] addr,
                       input logic [31:0] wdata, input int hold);
        logic [31:0] exp_d, da, db;
        logic        exp_e, ea, eb;
        logic [8:0]  pa0, pb0;
        int          exp_la, exp_lb, la, lb, ha, hb, wa0, wb0, c;
        bit          legal;
        legal = int'(addr) < DEPTH;
        da = '0; db = '0; ea = 1'b0; eb = 1'b0;
        if (!legal) begin
            exp_e = 1'b1; exp_d = '0; exp_la = 1; exp_lb = 1;
        end else if (we) begin
            exp_e = 1'b0; exp_d = wdata; exp_la = 2; exp_lb = 2;
            ref_mem[addr] = wdata;
        end else begin
            exp_e = 1'b0; exp_d = ref_mem[addr]; exp_la = 2; exp_lb = 4;
        end
        @(negedge clk);
        check("req_ready_a_idle", 32'(a_req_ready), 32'd1);
        check("req_ready_b_idle", 32'(b_req_ready), 32'd1);
        wa0 = a_wen; wb0 = b_wen;
        pa0 = a_mem_address; pb0 = b_mem_address;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        resp_ready = (hold == 0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        la = 0; lb = 0; ha = 0; hb = 0; c = 0;
        while ((la == 0 || lb == 0) && c < 40) begin
            @(negedge clk);
            c++;
            if (la == 0 && a_resp_valid) begin
                la = c; da = a_resp_rdata; ea = a_resp_err;
            end
            if (lb == 0 && b_resp_valid) begin
                lb = c; db = b_resp_rdata; eb = b_resp_err;
            end
            if (la == 0 && legal && !we && a_busy && a_mem_address == addr && !a_mem_w_en)
                ha++;
            if (lb == 0 && legal && !we && b_busy && b_mem_address == addr && !b_mem_w_en)
                hb++;
            if (a_mem_w_en) begin
                check("wr_mode_a", 32'(a_mem_mode), 32'd0);
                check("wr_addr_a", 32'(a_mem_address), 32'(addr));
                check("wr_data_a", a_mem_datain, wdata);
            end
            if (b_mem_w_en) begin
                check("wr_mode_b", 32'(b_mem_mode), 32'd0);
                check("wr_addr_b", 32'(b_mem_address), 32'(addr));
            end
        end
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1; req_we = 1'b1;
            req_addr = 9'd5; req_wdata = 32'hBAD0BAD0;
            @(negedge clk);
            check("hold_valid_a", 32'(a_resp_valid), 32'd1);
            check("hold_data_a", a_resp_rdata, exp_d);
            check("hold_ready_a", 32'(a_req_ready), 32'd0);
            check("hold_valid_b", 32'(b_resp_valid), 32'd1);
            check("hold_data_b", b_resp_rdata, exp_d);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        c = 0;
        while ((a_busy || b_busy) && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("idle_after", 32'(a_busy || b_busy), 32'd0);
        check("lat_a", 32'(la), 32'(exp_la));
        check("lat_b", 32'(lb), 32'(exp_lb));
        check("rdata_a", da, exp_d);
        check("rdata_b", db, exp_d);
        check("err_a", 32'(ea), 32'(exp_e));
        check("err_b", 32'(eb), 32'(exp_e));
        check("wen_cnt_a", 32'(a_wen - wa0), (legal && we) ? 32'd1 : 32'd0);
        check("wen_cnt_b", 32'(b_wen - wb0), (legal && we) ? 32'd1 : 32'd0);
        if (!legal) begin
            check("err_addr_a", 32'(a_mem_address), 32'(pa0));
            check("err_addr_b", 32'(b_mem_address), 32'(pb0));
        end
        if (legal && !we) begin
            check("rd_hold_a", 32'(ha), 32'd1);
            check("rd_hold_b", 32'(hb), 32'd3);
        end
    endtask

    task automatic rst_in_wr(input logic [8:0] addr, input logic [31:0] wdata);
        int wa0;
        @(negedge clk);
        wa0 = a_wen;
        req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rst_wr_wen_a", 32'(a_mem_w_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_wen_a", 32'(a_mem_w_en), 32'd0);
        check("rst_wen_b", 32'(b_mem_w_en), 32'd0);
        check("rst_valid_a", 32'(a_resp_valid), 32'd0);
        check("rst_mode_a", 32'(a_mem_mode), 32'd1);
        check("rst_busy_a", 32'(a_busy), 32'd0);
        check("rst_ready_a", 32'(a_req_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready_a", 32'(a_req_ready), 32'd1);
        check("post_rst_ready_b", 32'(b_req_ready), 32'd1);
        check("post_rst_valid_b", 32'(b_resp_valid), 32'd0);
        check("rst_wen_cnt_a", 32'(a_wen - wa0), 32'd1);
        // the enable was high for the whole cycle before reset: committed
        ref_mem[addr] = wdata;
    endtask

    initial begin
        logic        we;
        logic [8:0]  addr;
        int          hold;
        for (int i = 0; i < 512; i++) begin
            ref_mem[i] = (i < DEPTH) ? 32'd32 : 32'd0;
        end
        ref_mem[0] = 32'd3; ref_mem[1] = 32'd2; ref_mem[2] = 32'd1;
        ref_mem[3] = 32'd5; ref_mem[4] = 32'd4;
        for (int i = 0; i < 512; i++) begin
            a_mem[i] = ref_mem[i];
            b_mem[i] = ref_mem[i];
        end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_req_ready", 32'(a_req_ready), 32'd0);
        check("reset_resp_valid", 32'(a_resp_valid), 32'd0);
        check("reset_mem_mode", 32'(a_mem_mode), 32'd1);
        check("reset_mem_w_en", 32'(a_mem_w_en), 32'd0);
        check("reset_mem_address", 32'(a_mem_address), 32'd0);
        check("reset_mem_datain", a_mem_datain, 32'd0);
        check("reset_resp_rdata", a_resp_rdata, 32'd0);
        check("reset_resp_err", 32'(a_resp_err), 32'd0);
        check("reset_busy_b", 32'(b_busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 32'(a_req_ready), 32'd1);

        txn(1'b0, 9'd3, 32'h0, 0);
        txn(1'b1, 9'd4, 32'hDEADBEEF, 0);
        txn(1'b0, 9'd4, 32'h0, 0);
        txn(1'b0, 9'd100, 32'h0, 0);
        txn(1'b1, 9'd511, 32'h12345678, 0);
        txn(1'b0, 9'd99, 32'h0, 0);
        txn(1'b0, 9'd0, 32'h0, 5);
        txn(1'b0, 9'd1, 32'h0, 0);
        txn(1'b0, 9'd5, 32'h0, 0);
        rst_in_wr(9'd6, 32'hCAFEF00D);
        txn(1'b0, 9'd6, 32'h0, 0);

        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0)
                addr = 9'($urandom_range(100, 511));
            else
                addr = 9'($urandom_range(0, 99));
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : 0;
            txn(we, addr, $urandom, hold);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
